// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mc
//  Purpose  : Multi-cycle ALU behind valid/ready handshakes. Single-cycle ops
//             register their result on the accept edge; MUL runs a fixed
//             WIDTH-iteration shift-add before the result is presented.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       S,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic             zero,
  output logic             carry,
  output logic             ovf
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_mul  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  localparam logic [2:0] c_op_add = 3'b000;
  localparam logic [2:0] c_op_sub = 3'b001;
  localparam logic [2:0] c_op_and = 3'b010;
  localparam logic [2:0] c_op_or  = 3'b011;
  localparam logic [2:0] c_op_xor = 3'b100;
  localparam logic [2:0] c_op_slt = 3'b101;
  localparam logic [2:0] c_op_sll = 3'b110;
  localparam logic [2:0] c_op_mul = 3'b111;

  localparam logic [SHW-1:0] c_cnt_last = SHW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic             w_accept;
  logic             w_is_sub;
  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_carry;
  logic             w_alu_ovf;
  logic [WIDTH-1:0] w_acc_step;

  assign w_accept   = in_valid && (state_q == c_st_idle);
  // SUB reuses the adder as A + ~B + 1 so carry directly means "no borrow".
  assign w_is_sub   = (S == c_op_sub);
  assign w_b_op     = w_is_sub ? ~B : B;
  assign w_sum      = {1'b0, A} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_is_sub};
  assign w_acc_step = acc_q + (mplr_q[0] ? mcand_q : '0);

  // Single-cycle result and flags for the opcode currently on the inputs.
  always_comb begin
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    w_alu_ovf   = 1'b0;
    case (S)
      c_op_add, c_op_sub: begin
        w_alu_res   = w_sum[WIDTH-1:0];
        w_alu_carry = w_sum[WIDTH];
        // Same-sign addends (after B inversion) producing a different sign.
        w_alu_ovf   = (A[WIDTH-1] == w_b_op[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      c_op_and: w_alu_res = A & B;
      c_op_or:  w_alu_res = A | B;
      c_op_xor: w_alu_res = A ^ B;
      c_op_slt: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      c_op_sll: w_alu_res = A << B[SHW-1:0];
      default:  w_alu_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: if (w_accept) state_d = (S == c_op_mul) ? c_st_mul : c_st_done;
      c_st_mul:  if (cnt_q == c_cnt_last) state_d = c_st_done;
      c_st_done: if (out_ready) state_d = c_st_idle;
      default:   state_d = c_st_idle;
    endcase
  end

  // Datapath next values: capture on accept, iterate in MUL, hold otherwise.
  always_comb begin
    r_d     = r_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    case (state_q)
      c_st_idle: begin
        if (w_accept) begin
          if (S == c_op_mul) begin
            acc_d   = '0;
            mcand_d = A;
            mplr_d  = B;
            cnt_d   = '0;
          end else begin
            r_d     = w_alu_res;
            zero_d  = (w_alu_res == '0);
            carry_d = w_alu_carry;
            ovf_d   = w_alu_ovf;
          end
        end
      end
      c_st_mul: begin
        acc_d   = w_acc_step;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == c_cnt_last) begin
          r_d     = w_acc_step;
          zero_d  = (w_acc_step == '0);
          carry_d = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q     <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      r_q     <= r_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded from state and registered result.
  always_comb begin
    in_ready  = (state_q == c_st_idle);
    out_valid = (state_q == c_st_done);
    R         = r_q;
    zero      = zero_q;
    carry     = carry_q;
    ovf       = ovf_q;
  end

endmodule
`default_nettype wire

// File: doc/alu_mc.md
# alu_mc

Parametrised, multi-cycle successor to the 32-bit combinational ALU. It executes one operation at a time behind a valid/ready handshake on both input and output. Single-cycle ops return one cycle after acceptance; MUL is an iterative shift-add that takes WIDTH extra cycles. Status flags are produced alongside the registered result. The block sits between the decode/issue stage and writeback of the MiniMIPS datapath.

## Interface
- WIDTH, 32, datapath width. Must be a power of two, 8..64.
- SHW, $clog2(WIDTH), shift-amount width. Derived; do not override.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept. Equals (state==IDLE).
- A  in  WIDTH  operand 1.
- B  in  WIDTH  operand 2.
- S  in  3  opcode.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- R  out  WIDTH  registered result.
- zero  out  1  R == 0.
- carry  out  1  carry-out of ADD/SUB, else 0.
- ovf  out  1  signed overflow of ADD/SUB, else 0.

## Operation
- Opcodes:
  - 000 ADD: A+B.
  - 001 SUB: A+~B+1.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLT: signed A<B gives 1, else 0.
  - 110 SLL: A << B[SHW-1:0].
  - 111 MUL: low WIDTH bits of A*B (unsigned and signed give identical low bits).
- All arithmetic is modulo 2^WIDTH.
- carry is bit WIDTH of the (WIDTH+1)-bit sum. For SUB, carry=1 means no borrow (A>=B unsigned).
- ovf:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operand signs differ and the result sign differs from A.
- zero is computed on the final R for every op.
- A, B and S are sampled only on the accept edge (in_valid && in_ready). Later changes are ignored.
- State machine, states IDLE, MUL, DONE:
  - IDLE: in_ready=1.
    - On accept with S != 111: compute R and flags, register them, go to DONE.
    - On accept with S == 111: load acc=0, mcand=A, mplr=B, cnt=0, go to MUL.
  - MUL: each edge, if mplr[0] then acc += mcand. Then mcand <<= 1, mplr >>= 1, cnt++.
    - On the edge where cnt == WIDTH-1, write the final acc to R, set flags, go to DONE.
    - Always exactly WIDTH iterations; no early exit.
  - DONE: out_valid=1. R and flags are held stable. When out_ready=1, go to IDLE on that edge.
- Only one operation is in flight. in_ready=0 in MUL and DONE, and in_valid is ignored there.
- Reset (asynchronous, any state, including mid-MUL):
  - state=IDLE.
  - R, zero, carry, ovf = 0.
  - out_valid=0.
  - acc, mcand, mplr, cnt = 0.
  - Any in-flight op is discarded.
  - in_ready reads 1 during reset, but no accept occurs while rst_n=0.

## Timing
- Non-MUL op: accepted at edge 0; out_valid=1 and R valid after edge 0. Minimum 1 cycle in DONE, so max throughput is 1 op per 2 cycles.
- MUL: accepted at edge 0; iterations on edges 1..WIDTH; out_valid=1 after edge WIDTH. Latency is WIDTH+1 edges including accept (33 for WIDTH=32).
- Output handshake completes on the edge where out_valid && out_ready. in_ready rises after that edge, so the next accept can occur one edge later at the earliest.
- out_ready held low keeps the block in DONE indefinitely, with R, flags and out_valid unchanged.
- rst_n deassertion is synchronised externally. The first accept may occur on the first edge with rst_n=1.

## Test plan (WIDTH=32)
- ADD, A=0x02443282, B=0x37BBABFD, S=000 -> R=0x39FFDE7F, zero=0, carry=0, ovf=0, out_valid one cycle after accept.
- Same operands:
  - S=001 -> R=0xCA888685, carry=0, ovf=0.
  - S=010 -> R=0x02002280.
  - S=101 -> R=0x00000001.
- ADD A=0x7FFFFFFF, B=0x00000001 -> R=0x80000000, ovf=1, carry=0. SUB A=B=0x12345678 -> R=0, zero=1, carry=1.
- SLL A=0x00000001, B=0x00000025 -> R=0x00000020 (only B[4:0] used).
- MUL:
  - A=7, B=6 -> R=0x0000002A.
  - A=B=0xFFFFFFFF -> R=0x00000001.
  - For both: out_valid rises exactly 32 edges after the accept edge, and in_ready=0 throughout.
- Backpressure and reset:
  - Hold out_ready=0 for 3 cycles in DONE while toggling in_valid/A/B -> R stable, no new accept.
  - Then out_ready=1 -> IDLE; the next op is accepted one edge later.
  - Assert rst_n=0 at iteration 10 of a MUL -> out_valid=0, R=0, in_ready=1 immediately.
  - After release, a fresh ADD completes correctly.
